// File: rtl/regfile_dump_if.sv
// Dump-engine bus: register-file read port plus the outgoing byte stream (valid/ready).
interface regfile_dump_if #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned ADDR_W = 5
);
    logic [ADDR_W-1:0] rf_addr;
    logic [XLEN-1:0]   rf_data;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;

    modport master (
        output rf_addr,
        output tx_data,
        output tx_valid,
        input  rf_data,
        input  tx_ready
    );

    modport slave (
        input  rf_addr,
        input  tx_data,
        input  tx_valid,
        output rf_data,
        output tx_ready
    );
endinterface

// File: rtl/regfile_dump.sv
// Register-file dump engine: streams an 0xA5 header then every register LSB-first over valid/ready.
// Define DUMP_CHECKSUM_EN to append an XOR checksum byte of all data bytes.
module regfile_dump #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned NREGS  = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           i_start,
    output logic           o_busy,
    output logic           o_done,
    regfile_dump_if.master bus
);
    localparam int unsigned NBYTES   = XLEN / 8;
    localparam int unsigned CNT_W    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [7:0]  HDR_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_LOAD,
        S_SEND,
`ifdef DUMP_CHECKSUM_EN
        S_CSUM,
`endif
        S_DONE
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [XLEN-1:0]   r_shift, w_shift_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [ADDR_W-1:0] r_addr, w_addr_nxt;
    logic [7:0]        r_tx_data, w_tx_data_nxt;
    logic              r_tx_valid, w_tx_valid_nxt;
    logic              r_busy, r_done;
    logic              w_hs, w_last_byte, w_last_reg;
`ifdef DUMP_CHECKSUM_EN
    logic [7:0]        r_csum, w_csum_nxt;
`endif

    assign w_hs        = r_tx_valid & bus.tx_ready;
    assign w_last_byte = (r_cnt == CNT_W'(NBYTES - 1));
    assign w_last_reg  = (r_addr == ADDR_W'(NREGS - 1));

    // Next-state and datapath update; outputs are derived from the next state so they register cleanly
    always_comb begin
        w_state_nxt    = r_state;
        w_shift_nxt    = r_shift;
        w_cnt_nxt      = r_cnt;
        w_addr_nxt     = r_addr;
        w_tx_data_nxt  = 8'h00;
        w_tx_valid_nxt = 1'b0;
`ifdef DUMP_CHECKSUM_EN
        w_csum_nxt     = r_csum;
`endif
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nxt = S_HDR;
                    w_addr_nxt  = '0;
`ifdef DUMP_CHECKSUM_EN
                    w_csum_nxt  = 8'h00;
`endif
                end
            end
            S_HDR: begin
                if (w_hs) w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                w_shift_nxt = bus.rf_data;
                w_cnt_nxt   = '0;
                w_state_nxt = S_SEND;
            end
            S_SEND: begin
                if (w_hs) begin
                    w_shift_nxt = r_shift >> 8;
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
`ifdef DUMP_CHECKSUM_EN
                    w_csum_nxt  = r_csum ^ r_shift[7:0];
`endif
                    if (w_last_byte) begin
                        if (w_last_reg) begin
`ifdef DUMP_CHECKSUM_EN
                            w_state_nxt = S_CSUM;
`else
                            w_state_nxt = S_DONE;
`endif
                        end else begin
                            w_addr_nxt  = r_addr + ADDR_W'(1);
                            w_state_nxt = S_LOAD;
                        end
                    end
                end
            end
`ifdef DUMP_CHECKSUM_EN
            S_CSUM: begin
                if (w_hs) w_state_nxt = S_DONE;
            end
`endif
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase

        case (w_state_nxt)
            S_HDR: begin
                w_tx_valid_nxt = 1'b1;
                w_tx_data_nxt  = HDR_BYTE;
            end
            S_SEND: begin
                w_tx_valid_nxt = 1'b1;
                w_tx_data_nxt  = w_shift_nxt[7:0];
            end
`ifdef DUMP_CHECKSUM_EN
            S_CSUM: begin
                w_tx_valid_nxt = 1'b1;
                w_tx_data_nxt  = w_csum_nxt;
            end
`endif
            default: begin
                w_tx_valid_nxt = 1'b0;
                w_tx_data_nxt  = 8'h00;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_shift    <= '0;
            r_cnt      <= '0;
            r_addr     <= '0;
            r_tx_data  <= 8'h00;
            r_tx_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
            r_csum     <= 8'h00;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_shift    <= w_shift_nxt;
            r_cnt      <= w_cnt_nxt;
            r_addr     <= w_addr_nxt;
            r_tx_data  <= w_tx_data_nxt;
            r_tx_valid <= w_tx_valid_nxt;
            r_busy     <= (w_state_nxt != S_IDLE);
            r_done     <= (w_state_nxt == S_DONE);
`ifdef DUMP_CHECKSUM_EN
            r_csum     <= w_csum_nxt;
`endif
        end
    end

    assign bus.rf_addr  = r_addr;
    assign bus.tx_data  = r_tx_data;
    assign bus.tx_valid = r_tx_valid;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
endmodule

// File: tb/tb_regfile_dump.sv
// Randomized self-checking bench for regfile_dump against a frame-level reference model.
module tb_regfile_dump;
    localparam int unsigned XLEN   = 32;
    localparam int unsigned NREGS  = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned NBYTES = XLEN / 8;
`ifdef DUMP_CHECKSUM_EN
    localparam int unsigned FRAME_LEN = 2 + NREGS * NBYTES;
    localparam int unsigned BUSY_LEN  = 3 + NREGS * (1 + NBYTES);
`else
    localparam int unsigned FRAME_LEN = 1 + NREGS * NBYTES;
    localparam int unsigned BUSY_LEN  = 2 + NREGS * (1 + NBYTES);
`endif

    logic clk;
    logic reset;
    logic start;
    logic busy;
    logic done;
    logic rand_ready;

    logic [XLEN-1:0] rf_mem [NREGS];
    logic [7:0]      rx_q[$];
    logic [7:0]      exp_q[$];
    int              busy_cnt;
    int              done_cnt;
    int              n_checks;
    int              n_fail;

    regfile_dump_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) bus ();

    regfile_dump #(.XLEN(XLEN), .NREGS(NREGS), .ADDR_W(ADDR_W)) dut (
        .clk     (clk),
        .reset   (reset),
        .i_start (start),
        .o_busy  (busy),
        .o_done  (done),
        .bus     (bus)
    );

    assign bus.rf_data = rf_mem[bus.rf_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sink: random or constant ready, changed just after each rising edge
    initial begin
        bus.tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: collect accepted bytes, count busy/done cycles, verify stalls hold the byte
    initial begin
        logic       prev_stall;
        logic [7:0] prev_data;
        prev_stall = 1'b0;
        prev_data  = 8'h00;
        forever begin
            @(negedge clk);
            if (prev_stall) begin
                check("stall_valid", 32'(bus.tx_valid), 32'd1);
                check("stall_data", 32'(bus.tx_data), 32'(prev_data));
            end
            if (bus.tx_valid && bus.tx_ready) rx_q.push_back(bus.tx_data);
            if (busy) busy_cnt++;
            if (done) done_cnt++;
            prev_stall = reset && bus.tx_valid && !bus.tx_ready;
            prev_data  = bus.tx_data;
        end
    end

    // Reference frame: header, each register LSB first, optional XOR of data bytes
    task automatic build_exp();
`ifdef DUMP_CHECKSUM_EN
        logic [7:0] cs;
        cs = 8'h00;
`endif
        exp_q.delete();
        exp_q.push_back(8'hA5);
        for (int r = 0; r < int'(NREGS); r++) begin
            for (int b = 0; b < int'(NBYTES); b++) begin
                exp_q.push_back(8'(rf_mem[r] >> (8 * b)));
`ifdef DUMP_CHECKSUM_EN
                cs = cs ^ 8'(rf_mem[r] >> (8 * b));
`endif
            end
        end
`ifdef DUMP_CHECKSUM_EN
        exp_q.push_back(cs);
`endif
    endtask

    task automatic compare_frame(input int off);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (off + i < rx_q.size()) check($sformatf("byte%0d", i), 32'(rx_q[off + i]), 32'(exp_q[i]));
            else check($sformatf("missing%0d", i), 32'd0, 32'd1);
        end
    endtask

    task automatic wait_frame(output bit ok);
        int d0;
        d0 = done_cnt;
        ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            tick();
            if (done_cnt != d0) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic wait_bytes(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (rx_q.size() >= n) begin
                ok = 1'b1;
                return;
            end
            tick();
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_frame(input bit rnd);
        bit ok;
        int d0;
        build_exp();
        rand_ready = rnd;
        rx_q.delete();
        busy_cnt = 0;
        d0 = done_cnt;
        pulse_start();
        check("hdr_valid", 32'(bus.tx_valid), 32'd1);
        check("hdr_data", 32'(bus.tx_data), 32'hA5);
        wait_frame(ok);
        check("frame_timeout", 32'(ok), 32'd1);
        check("frame_len", 32'(rx_q.size()), 32'(FRAME_LEN));
        compare_frame(0);
        check("done_once", 32'(done_cnt - d0), 32'd1);
        if (!rnd) check("busy_len", 32'(busy_cnt), 32'(BUSY_LEN));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 32'(bus.tx_valid), 32'd0);
        check({tag, "_data"}, 32'(bus.tx_data), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_addr"}, 32'(bus.rf_addr), 32'd0);
    endtask

    initial begin
        bit ok;
        int gap;
        n_checks   = 0;
        n_fail     = 0;
        busy_cnt   = 0;
        done_cnt   = 0;
        reset      = 1'b0;
        start      = 1'b0;
        rand_ready = 1'b0;
        for (int r = 0; r < int'(NREGS); r++) rf_mem[r] = XLEN'(r);
        rf_mem[1] = 32'hDEADBEEF;

        repeat (3) tick();
        check_reset_outputs("por");
        reset = 1'b1;
        repeat (2) tick();

        // Basic dump and the same registers under backpressure
        run_frame(1'b0);
        run_frame(1'b1);

        // Random register contents, random backpressure
        for (int k = 0; k < 2; k++) begin
            for (int r = 0; r < int'(NREGS); r++) rf_mem[r] = $urandom;
            run_frame(1'b1);
        end

        // Start pulsed mid-SEND is ignored
        build_exp();
        rand_ready = 1'b0;
        rx_q.delete();
        pulse_start();
        wait_bytes(20, ok);
        check("mid_wait", 32'(ok), 32'd1);
        pulse_start();
        wait_frame(ok);
        check("mid_timeout", 32'(ok), 32'd1);
        check("mid_len", 32'(rx_q.size()), 32'(FRAME_LEN));
        compare_frame(0);
        busy_cnt = 0;
        repeat (10) tick();
        check("mid_no_restart", 32'(busy_cnt), 32'd0);

        // Start held high: back-to-back frames with a single idle cycle
        build_exp();
        rx_q.delete();
        start = 1'b1;
        wait_frame(ok);
        check("held_timeout1", 32'(ok), 32'd1);
        gap = 0;
        for (int i = 0; i < 10; i++) begin
            if (busy) break;
            gap++;
            tick();
        end
        start = 1'b0;
        check("held_gap", 32'(gap), 32'd1);
        wait_frame(ok);
        check("held_timeout2", 32'(ok), 32'd1);
        check("held_len", 32'(rx_q.size()), 32'(2 * FRAME_LEN));
        compare_frame(int'(FRAME_LEN));
        tick();

        // Reset after 40 accepted bytes abandons the frame
        rand_ready = 1'b1;
        rx_q.delete();
        pulse_start();
        wait_bytes(40, ok);
        check("rst_wait", 32'(ok), 32'd1);
        reset = 1'b0;
        #1;
        check_reset_outputs("rst_async");
        repeat (3) tick();
        check_reset_outputs("rst_hold");
        reset = 1'b1;
        tick();
        run_frame(1'b0);

        // Checksum stimulus: only x1 nonzero
        for (int r = 0; r < int'(NREGS); r++) rf_mem[r] = '0;
        rf_mem[1] = 32'hDEADBEEF;
        run_frame(1'b0);
        if (rx_q.size() > 0) begin
`ifdef DUMP_CHECKSUM_EN
            check("csum_byte", 32'(rx_q[rx_q.size() - 1]), 32'h22);
`else
            check("last_byte", 32'(rx_q[rx_q.size() - 1]), 32'h00);
`endif
        end else begin
            check("csum_empty", 32'd0, 32'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/regfile_dump.md
# regfile_dump

Debug read-out engine for the single-cycle RISC-V core. It walks the core's register file on demand, reading every architectural register through a dedicated read port. It streams the contents as a framed byte sequence over a valid/ready interface. It is the read-back counterpart to the register/instruction-memory preload path: loads put state into the core, and this block gets it out without simulator hierarchy access.

## Interface
- XLEN, 32, register width in bits; must be a multiple of 8
- NREGS, 32, number of registers dumped (x0..x(NREGS-1))
- ADDR_W, 5, register address width; clog2(NREGS)
- clk  in  1  system clock, rising-edge active
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- start  in  1  request a dump; sampled in IDLE only
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse in the final cycle of a frame
- rf_addr  out  ADDR_W  register file read address
- rf_data  in  XLEN  register file read data, combinational from rf_addr
- tx_data  out  8  stream byte
- tx_valid  out  1  tx_data is valid
- tx_ready  in  1  sink accepts the byte; handshake = tx_valid & tx_ready at a rising edge

## Operation
- Frame format:
  - header byte 0xA5
  - then for each register 0..NREGS-1: XLEN/8 bytes, least-significant byte first
  - optional checksum byte (see Configuration)
- FSM states: IDLE, HDR, LOAD, SEND, CSUM, DONE.
- IDLE:
  - start=1 -> HDR; rf_addr cleared to 0.
  - start is ignored in all other states.
- HDR: tx_valid=1, tx_data=0xA5; on handshake -> LOAD.
- LOAD:
  - tx_valid=0.
  - Capture rf_data into XLEN shift register; clear byte counter -> SEND.
- SEND:
  - tx_valid=1, tx_data = low byte of shift register.
  - On handshake, shift right 8 and increment byte counter.
  - After byte XLEN/8-1 of the last register (rf_addr = NREGS-1) -> CSUM if enabled, else DONE.
  - After byte XLEN/8-1 of any other register: rf_addr+1 -> LOAD.
- CSUM: tx_valid=1, tx_data = checksum; on handshake -> DONE.
- DONE: tx_valid=0, done=1 for exactly one cycle -> IDLE.
- Snapshot semantics:
  - Each register is sampled in its own LOAD cycle; the dump is not atomic.
  - The core is to be held/halted by the integrator if consistency matters.
- x0 is transmitted as whatever rf_data returns; architecturally this is 0.

## Timing
- Reset values: busy=0, done=0, tx_valid=0, tx_data=0x00, rf_addr=0; FSM=IDLE, checksum=0.
- Reset is asynchronous: asserting reset mid-frame drops tx_valid and busy immediately; the frame is abandoned.
- start=1 at edge k (IDLE) -> header valid after edge k.
- Header accepted at edge h -> LOAD cycle -> first data byte valid after edge h+1.
- Valid/ready rules:
  - While tx_valid=1 and tx_ready=0, tx_data is held stable and tx_valid is not deasserted.
  - tx_valid does not depend combinationally on tx_ready.
- With tx_ready held 1, busy lasts 1 (HDR) + NREGS*(1+XLEN/8) + 1 (DONE) cycles: 162 for defaults, 163 with checksum.
- start held high continuously -> back-to-back frames separated by exactly one IDLE cycle.
- rf_addr changes only on the LOAD transition; it is stable throughout SEND.

## Configuration
- DUMP_CHECKSUM_EN defined:
  - An 8-bit XOR of all register data bytes (header excluded) is accumulated on each data-byte handshake.
  - It is sent as the final byte via CSUM.
  - The accumulator clears on entering HDR.
  - Frame length is 2 + NREGS*XLEN/8 bytes (130 for defaults).
- DUMP_CHECKSUM_EN undefined:
  - No CSUM state and no accumulator logic.
  - Frame length is 1 + NREGS*XLEN/8 bytes (129 for defaults).

## Test plan
- Basic dump:
  - Stimulus: x[i]=i, x1=0xDEADBEEF, tx_ready=1, one start pulse.
  - Response: bytes A5, 00 00 00 00, EF BE AD DE, 02 00 00 00, ..., 1F 00 00 00; 129 bytes total; done pulses once; busy high 162 cycles.
- Backpressure:
  - Stimulus: same registers, tx_ready toggling 1,0,0,1 pseudo-randomly.
  - Response: identical byte sequence; tx_data/tx_valid never change while stalled; no byte duplicated or dropped.
- Start handling:
  - Stimulus: start pulsed during SEND.
  - Response: ignored; a single frame.
  - Stimulus: start held high.
  - Response: consecutive frames with a one-cycle IDLE gap (busy=0 for exactly one cycle).
- Reset mid-frame:
  - Stimulus: assert reset after 40 byte handshakes, release, then start.
  - Response: all outputs at reset values during reset; the new frame begins with A5 and is complete and correct.
- Checksum (DUMP_CHECKSUM_EN):
  - Stimulus: all registers 0 except x1=0xDEADBEEF.
  - Response: final byte 0x22; 130 bytes; busy 163 cycles.
  - Without the macro: same stimulus yields 129 bytes, with no trailing byte.
